// File: rtl/cpu_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential bytes from fpc into a small FIFO for the decoder.
// Define CPU_PREFETCH_BYPASS_EN to forward an acked byte straight to an empty, ready consumer.
module cpu_prefetch_queue #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_data,
    output logic                    q_valid,
    input  logic                    q_ready,
    output logic [DATA_W-1:0]       q_data,
    output logic [ADDR_W-1:0]       q_pc,
    input  logic                    redirect,
    input  logic [ADDR_W-1:0]       redirect_pc,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] pc_q [DEPTH];

    logic xfer;
    logic wr_en;
    logic head_valid;
    logic pop;

    assign mem_addr = fpc_q;
    assign level    = level_q;

    always_comb begin
        mem_req    = (level_q < FULL_LVL) && !redirect && !rst;
        xfer       = mem_req && mem_ack;
        head_valid = (level_q != '0) && !redirect && !rst;
        pop        = head_valid && q_ready;
    end

`ifdef CPU_PREFETCH_BYPASS_EN
    logic bypass;

    // mem_req already excludes redirect and reset, so the bypass inherits both.
    always_comb begin
        bypass  = xfer && (level_q == '0) && q_ready;
        wr_en   = xfer && !bypass;
        q_valid = head_valid || bypass;
        if (rst) begin
            q_data = '0;
            q_pc   = '0;
        end else if (bypass) begin
            q_data = mem_data;
            q_pc   = fpc_q;
        end else begin
            q_data = data_q[head_q];
            q_pc   = pc_q[head_q];
        end
    end
`else
    always_comb begin
        wr_en   = xfer;
        q_valid = head_valid;
        if (rst) begin
            q_data = '0;
            q_pc   = '0;
        end else begin
            q_data = data_q[head_q];
            q_pc   = pc_q[head_q];
        end
    end
`endif

    always_comb begin
        fpc_d   = fpc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        if (redirect) begin
            fpc_d   = redirect_pc;
            head_d  = '0;
            tail_d  = '0;
            level_d = '0;
        end else begin
            if (xfer) fpc_d = fpc_q + ADDR_W'(1);
            if (wr_en) tail_d = tail_q + PTR_W'(1);
            if (pop) head_d = head_q + PTR_W'(1);
            unique case ({wr_en, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q   <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            fpc_q   <= fpc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (wr_en) begin
            data_q[tail_q] <= mem_data;
            pc_q[tail_q]   <= fpc_q;
        end
    end

endmodule

// File: doc/cpu_prefetch_queue.md
CPU_PREFETCH_QUEUE -- requirements
Module: cpu_prefetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning fetch address width.
REQ-002 SHALL have parameter DATA_W, default 8, meaning opcode/operand byte width.
REQ-003 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-005 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  meaning reset; asynchronous, active-high.
REQ-007 SHALL have port mem_req  output  1  meaning fetch request valid.
REQ-008 SHALL have port mem_addr  output  ADDR_W  meaning fetch address (fetch PC).
REQ-009 SHALL have port mem_ack  input  1  meaning memory returns mem_data this cycle.
REQ-010 SHALL have port mem_data  input  DATA_W  meaning fetched byte.
REQ-011 SHALL have port q_valid  output  1  meaning head entry available.
REQ-012 SHALL have port q_ready  input  1  meaning consumer (decoder) takes the head.
REQ-013 SHALL have port q_data  output  DATA_W  meaning head byte.
REQ-014 SHALL have port q_pc  output  ADDR_W  meaning address the head byte was fetched from.
REQ-015 SHALL have port redirect  input  1  meaning flush queue and restart fetch (branch/jump/interrupt).
REQ-016 SHALL have port redirect_pc  input  ADDR_W  meaning new fetch address.
REQ-017 SHALL have port level  output  clog2(DEPTH)+1  meaning current entry count.

Function
REQ-018 SHALL hold fetch PC (fpc); mem_addr = fpc combinationally.
REQ-019 SHALL drive mem_req = (level < DEPTH) && !redirect && !rst.
REQ-020 SHALL treat mem_req && mem_ack as a fetch transfer: write {mem_data, fpc} at the tail and set fpc <= fpc+1.
REQ-021 SHALL increment fpc modulo 2^ADDR_W (0xFFFF -> 0x0000 at default width).
REQ-022 SHALL hold mem_addr stable while mem_req is high and mem_ack is low; mem_ack without mem_req SHALL be ignored.
REQ-023 SHALL drive q_valid = (level != 0) && !redirect, with q_data/q_pc from the head entry.
REQ-024 SHALL treat q_valid && q_ready as a pop: the head advances; level decrements.
REQ-025 SHALL make level unchanged on a simultaneous push and pop, including at level == DEPTH-1 and level == 1.
REQ-026 SHALL wrap head/tail pointers modulo DEPTH.
REQ-027 SHALL never overflow: at level == DEPTH, mem_req is low, so no push occurs.
REQ-028 SHALL never underflow: no pop occurs at level 0.
REQ-029 SHALL, in a cycle with redirect high, discard any mem_ack data, suppress any pop, and then have level = 0 and fpc = redirect_pc, with pointers reset, on the next edge.
REQ-030 SHALL, on back-to-back redirects, take the last redirect_pc.
REQ-031 SHALL have a latency of one cycle from a push at level 0 to q_valid high (without bypass).

Reset
REQ-032 SHALL, while rst is high, asynchronously force level = 0, pointers = 0, fpc = RESET_PC, mem_req = 0, q_valid = 0.
REQ-033 SHALL force q_data and q_pc to 0 during reset.
REQ-034 SHALL assert mem_req with mem_addr = RESET_PC in the first cycle after rst deasserts.
REQ-035 SHALL discard in-flight fetch state on reset asserted mid-operation; no entry survives reset.

Configuration
REQ-036 SHALL, with macro CPU_PREFETCH_BYPASS_EN defined, forward data in the cycle a transfer occurs when level == 0, q_ready is high and redirect is low: q_valid = 1, q_data = mem_data, q_pc = fpc; the byte is consumed and not written to the queue, fpc increments and level stays 0.
REQ-037 SHALL, without CPU_PREFETCH_BYPASS_EN, never combinationally connect mem_data to q_data; minimum ack-to-q_valid latency is 1 cycle.

Verification
REQ-038 SHALL cover reset release with RESET_PC=0x8000 and mem_ack held high, q_ready low: addresses 0x8000..0x8003 pushed, mem_req drops at level=4, and q_pc=0x8000.
REQ-039 SHALL cover streaming with mem_ack=1 and q_ready=1 continuously: one byte per cycle, level steady at 1 (0 with bypass), and q_pc sequential.
REQ-040 SHALL cover redirect with redirect_pc=0x1234 at level=3 and mem_ack high: the acked byte is dropped, q_valid is low that cycle, then level=0 and the next mem_addr=0x1234.
REQ-041 SHALL cover wrap with redirect to 0xFFFE and three acks: q_pc sequence is 0xFFFE, 0xFFFF, 0x0000.
REQ-042 SHALL cover rst pulsed asynchronously mid-stream at level=2: q_valid and mem_req go 0 immediately, and fetch restarts at RESET_PC.
REQ-043 SHALL cover, with CPU_PREFETCH_BYPASS_EN at level=0 and ack+ready together, mem_data=0xA9: q_valid=1 and q_data=0xA9 in the same cycle, and level remains 0.
